// File: rtl/ysyx_23060184_mem_arbiter_if.sv
// Bundle of the IFU, LSU and SRAM-side AXI-lite channels around the memory arbiter.
// The master modport is the arbiter's view; the slave modport is the view of the masters and SRAM.
interface ysyx_23060184_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 4,
    parameter int RESP_W = 2
);
    logic [ADDR_W-1:0] ifu_araddr;
    logic              ifu_arvalid;
    logic              ifu_arready;
    logic [DATA_W-1:0] ifu_rdata;
    logic [RESP_W-1:0] ifu_rresp;
    logic              ifu_rvalid;
    logic              ifu_rready;

    logic [ADDR_W-1:0] lsu_araddr;
    logic              lsu_arvalid;
    logic              lsu_arready;
    logic [DATA_W-1:0] lsu_rdata;
    logic [RESP_W-1:0] lsu_rresp;
    logic              lsu_rvalid;
    logic              lsu_rready;
    logic [ADDR_W-1:0] lsu_awaddr;
    logic              lsu_awvalid;
    logic              lsu_awready;
    logic [DATA_W-1:0] lsu_wdata;
    logic [STRB_W-1:0] lsu_wstrb;
    logic              lsu_wvalid;
    logic              lsu_wready;
    logic [RESP_W-1:0] lsu_bresp;
    logic              lsu_bvalid;
    logic              lsu_bready;

    logic [ADDR_W-1:0] mem_araddr;
    logic              mem_arvalid;
    logic              mem_arready;
    logic [DATA_W-1:0] mem_rdata;
    logic [RESP_W-1:0] mem_rresp;
    logic              mem_rvalid;
    logic              mem_rready;
    logic [ADDR_W-1:0] mem_awaddr;
    logic              mem_awvalid;
    logic              mem_awready;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [RESP_W-1:0] mem_bresp;
    logic              mem_bvalid;
    logic              mem_bready;

    modport master (
        input  ifu_araddr, ifu_arvalid, ifu_rready,
        output ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid,
        input  lsu_araddr, lsu_arvalid, lsu_rready,
        output lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
        input  lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid, lsu_bready,
        output lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
        output mem_araddr, mem_arvalid, mem_rready,
        input  mem_arready, mem_rdata, mem_rresp, mem_rvalid,
        output mem_awaddr, mem_awvalid, mem_wdata, mem_wstrb, mem_wvalid, mem_bready,
        input  mem_awready, mem_wready, mem_bresp, mem_bvalid
    );

    modport slave (
        output ifu_araddr, ifu_arvalid, ifu_rready,
        input  ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid,
        output lsu_araddr, lsu_arvalid, lsu_rready,
        input  lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
        output lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid, lsu_bready,
        input  lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
        input  mem_araddr, mem_arvalid, mem_rready,
        output mem_arready, mem_rdata, mem_rresp, mem_rvalid,
        input  mem_awaddr, mem_awvalid, mem_wdata, mem_wstrb, mem_wvalid, mem_bready,
        output mem_awready, mem_wready, mem_bresp, mem_bvalid
    );
endinterface

// File: rtl/ysyx_23060184_mem_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI-lite arbiter for the shared SRAM port.
// One whole transaction is granted at a time; LSU has fixed priority over IFU.
module ysyx_23060184_mem_arbiter (
    input  logic                               clk,
    input  logic                               reset,
    ysyx_23060184_mem_arbiter_if.master        bus,
    output logic [1:0]                         grant
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IFU_RD = 2'b01,
        LSU_RD = 2'b10,
        LSU_WR = 2'b11
    } state_e;

    state_e state_q, state_d;
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q,  w_done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign grant = state_q;

    always_comb begin
        state_d   = state_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        bus.ifu_arready = 1'b0;
        bus.ifu_rdata   = '0;
        bus.ifu_rresp   = '0;
        bus.ifu_rvalid  = 1'b0;
        bus.lsu_arready = 1'b0;
        bus.lsu_rdata   = '0;
        bus.lsu_rresp   = '0;
        bus.lsu_rvalid  = 1'b0;
        bus.lsu_awready = 1'b0;
        bus.lsu_wready  = 1'b0;
        bus.lsu_bresp   = '0;
        bus.lsu_bvalid  = 1'b0;
        bus.mem_araddr  = '0;
        bus.mem_arvalid = 1'b0;
        bus.mem_rready  = 1'b0;
        bus.mem_awaddr  = '0;
        bus.mem_awvalid = 1'b0;
        bus.mem_wdata   = '0;
        bus.mem_wstrb   = '0;
        bus.mem_wvalid  = 1'b0;
        bus.mem_bready  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.lsu_arvalid)                          state_d = LSU_RD;
                else if (bus.lsu_awvalid || bus.lsu_wvalid)   state_d = LSU_WR;
                else if (bus.ifu_arvalid)                     state_d = IFU_RD;
            end
            IFU_RD: begin
                bus.mem_araddr  = bus.ifu_araddr;
                bus.mem_arvalid = bus.ifu_arvalid && !ar_done_q;
                bus.ifu_arready = bus.mem_arready && !ar_done_q;
                bus.mem_rready  = bus.ifu_rready;
                bus.ifu_rdata   = bus.mem_rdata;
                bus.ifu_rresp   = bus.mem_rresp;
                bus.ifu_rvalid  = bus.mem_rvalid;
                if (bus.ifu_arvalid && !ar_done_q && bus.mem_arready) ar_done_d = 1'b1;
                if (bus.mem_rvalid && bus.ifu_rready) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end
            LSU_RD: begin
                bus.mem_araddr  = bus.lsu_araddr;
                bus.mem_arvalid = bus.lsu_arvalid && !ar_done_q;
                bus.lsu_arready = bus.mem_arready && !ar_done_q;
                bus.mem_rready  = bus.lsu_rready;
                bus.lsu_rdata   = bus.mem_rdata;
                bus.lsu_rresp   = bus.mem_rresp;
                bus.lsu_rvalid  = bus.mem_rvalid;
                if (bus.lsu_arvalid && !ar_done_q && bus.mem_arready) ar_done_d = 1'b1;
                if (bus.mem_rvalid && bus.lsu_rready) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end
            LSU_WR: begin
                // AW and W complete independently; B is only exposed once both have landed.
                bus.mem_awaddr  = bus.lsu_awaddr;
                bus.mem_awvalid = bus.lsu_awvalid && !aw_done_q;
                bus.lsu_awready = bus.mem_awready && !aw_done_q;
                bus.mem_wdata   = bus.lsu_wdata;
                bus.mem_wstrb   = bus.lsu_wstrb;
                bus.mem_wvalid  = bus.lsu_wvalid && !w_done_q;
                bus.lsu_wready  = bus.mem_wready && !w_done_q;
                if (bus.lsu_awvalid && !aw_done_q && bus.mem_awready) aw_done_d = 1'b1;
                if (bus.lsu_wvalid && !w_done_q && bus.mem_wready)    w_done_d  = 1'b1;
                if (aw_done_q && w_done_q) begin
                    bus.mem_bready = bus.lsu_bready;
                    bus.lsu_bvalid = bus.mem_bvalid;
                    bus.lsu_bresp  = bus.mem_bresp;
                    if (bus.mem_bvalid && bus.lsu_bready) begin
                        state_d   = IDLE;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ysyx_23060184_mem_arbiter.sv
// Directed bench for the memory arbiter: a scoreboard of expected R/B responses checked by a
// monitor, a small SRAM slave model (data = address halves swapped), and inline timing checks.
module tb_ysyx_23060184_mem_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant;

    always #5 clk = ~clk;

    ysyx_23060184_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .STRB_W(4), .RESP_W(2)) bus ();

    ysyx_23060184_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .grant (grant)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [33:0] q_ifu[$];
    logic [33:0] q_lsu[$];
    logic [1:0]  q_b[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0: return bus.ifu_arvalid && bus.ifu_arready;
            1: return bus.lsu_arvalid && bus.lsu_arready;
            2: return bus.ifu_rvalid && bus.ifu_rready;
            3: return bus.lsu_rvalid && bus.lsu_rready;
            4: return bus.lsu_bvalid && bus.lsu_bready;
            5: return bus.lsu_awvalid && bus.lsu_awready;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string nm);
        int n = 0;
        @(negedge clk);
        while (!cond(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cond(sel)) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout_%s: handshake not seen after %0d cycles, expected within 50", nm, n);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        logic [33:0] e;
        logic [1:0]  eb;
        if (!reset) begin
            if (bus.ifu_rvalid && bus.ifu_rready) begin
                if (q_ifu.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL ifu_r_unexpected: got data 0x%0h, expected no response", bus.ifu_rdata);
                end else begin
                    e = q_ifu.pop_front();
                    chk("ifu_rdata", bus.ifu_rdata, e[33:2]);
                    chk("ifu_rresp", {30'd0, bus.ifu_rresp}, {30'd0, e[1:0]});
                end
            end
            if (bus.lsu_rvalid && bus.lsu_rready) begin
                if (q_lsu.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL lsu_r_unexpected: got data 0x%0h, expected no response", bus.lsu_rdata);
                end else begin
                    e = q_lsu.pop_front();
                    chk("lsu_rdata", bus.lsu_rdata, e[33:2]);
                    chk("lsu_rresp", {30'd0, bus.lsu_rresp}, {30'd0, e[1:0]});
                end
            end
            if (bus.lsu_bvalid && bus.lsu_bready) begin
                if (q_b.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL lsu_b_unexpected: got bresp 0x%0h, expected no response", bus.lsu_bresp);
                end else begin
                    eb = q_b.pop_front();
                    chk("lsu_bresp", {30'd0, bus.lsu_bresp}, {30'd0, eb});
                end
            end
        end
    end

    // SRAM slave model
    int unsigned cfg_ar_wait = 0;
    int unsigned cfg_r_delay = 0;
    logic [1:0]  cfg_rresp   = 2'b00;
    logic [1:0]  cfg_bresp   = 2'b00;
    logic        cfg_wready  = 1'b1;

    logic        s_ar_hs, s_r_hs, s_aw_hs, s_w_hs, s_b_hs, s_arv;
    logic [31:0] s_araddr;

    always @(negedge clk) begin
        s_ar_hs  <= bus.mem_arvalid && bus.mem_arready;
        s_r_hs   <= bus.mem_rvalid && bus.mem_rready;
        s_aw_hs  <= bus.mem_awvalid && bus.mem_awready;
        s_w_hs   <= bus.mem_wvalid && bus.mem_wready;
        s_b_hs   <= bus.mem_bvalid && bus.mem_bready;
        s_arv    <= bus.mem_arvalid;
        s_araddr <= bus.mem_araddr;
    end

    initial begin : slave
        int unsigned ar_cnt;
        int unsigned r_cnt;
        logic        r_pend, aw_got, w_got;
        logic [31:0] lat;
        ar_cnt = 0; r_cnt = 0; r_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; lat = '0;
        bus.mem_arready = 1'b0; bus.mem_rdata = '0; bus.mem_rresp = '0; bus.mem_rvalid = 1'b0;
        bus.mem_awready = 1'b0; bus.mem_wready = 1'b0; bus.mem_bresp = '0; bus.mem_bvalid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                ar_cnt = 0; r_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
                bus.mem_rvalid = 1'b0; bus.mem_bvalid = 1'b0;
                bus.mem_arready = 1'b0; bus.mem_awready = 1'b0; bus.mem_wready = 1'b0;
            end else begin
                if (s_ar_hs) begin
                    r_pend = 1'b1; r_cnt = cfg_r_delay; ar_cnt = 0; lat = s_araddr;
                end else if (s_arv) begin
                    ar_cnt++;
                end
                if (s_r_hs) begin
                    bus.mem_rvalid = 1'b0; r_pend = 1'b0;
                end else if (r_pend && !bus.mem_rvalid) begin
                    if (r_cnt == 0) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = {lat[15:0], lat[31:16]};
                        bus.mem_rresp  = cfg_rresp;
                    end else begin
                        r_cnt--;
                    end
                end
                bus.mem_arready = !r_pend && (ar_cnt >= cfg_ar_wait);
                if (s_aw_hs) aw_got = 1'b1;
                if (s_w_hs)  w_got  = 1'b1;
                if (s_b_hs) begin
                    bus.mem_bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0;
                end else if (aw_got && w_got && !bus.mem_bvalid) begin
                    bus.mem_bvalid = 1'b1;
                    bus.mem_bresp  = cfg_bresp;
                end
                bus.mem_awready = 1'b1;
                bus.mem_wready  = cfg_wready;
            end
        end
    end

    task automatic ifu_read(input logic [31:0] addr);
        tick();
        bus.ifu_araddr  = addr;
        bus.ifu_arvalid = 1'b1;
        wait_for(0, "ifu_ar");
        chk("ifu_grant", {30'd0, grant}, 32'h1);
        tick();
        bus.ifu_arvalid = 1'b0;
        wait_for(2, "ifu_r");
        tick();
    endtask

    task automatic lsu_read(input logic [31:0] addr);
        tick();
        bus.lsu_araddr  = addr;
        bus.lsu_arvalid = 1'b1;
        wait_for(1, "lsu_ar");
        chk("lsu_rd_grant", {30'd0, grant}, 32'h2);
        tick();
        bus.lsu_arvalid = 1'b0;
        wait_for(3, "lsu_r");
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.ifu_araddr = '0; bus.ifu_arvalid = 1'b0; bus.ifu_rready = 1'b1;
        bus.lsu_araddr = '0; bus.lsu_arvalid = 1'b0; bus.lsu_rready = 1'b1;
        bus.lsu_awaddr = '0; bus.lsu_awvalid = 1'b0;
        bus.lsu_wdata  = '0; bus.lsu_wstrb  = '0; bus.lsu_wvalid = 1'b0; bus.lsu_bready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 32'h0);
        chk("rst_mem_arvalid", {31'd0, bus.mem_arvalid}, 32'h0);
        chk("rst_mem_rready", {31'd0, bus.mem_rready}, 32'h0);
        chk("rst_mem_bready", {31'd0, bus.mem_bready}, 32'h0);
        chk("rst_ifu_arready", {31'd0, bus.ifu_arready}, 32'h0);
        tick(); tick();
        reset = 1'b0;

        // IFU-only read, zero-wait slave
        tick();
        bus.ifu_araddr = 32'h5678_1234; bus.ifu_arvalid = 1'b1;
        q_ifu.push_back({32'h1234_5678, 2'b00});
        @(negedge clk);
        chk("t1_c0_grant", {30'd0, grant}, 32'h0);
        chk("t1_c0_mem_arvalid", {31'd0, bus.mem_arvalid}, 32'h0);
        tick(); @(negedge clk);
        chk("t1_c1_grant", {30'd0, grant}, 32'h1);
        chk("t1_c1_mem_arvalid", {31'd0, bus.mem_arvalid}, 32'h1);
        chk("t1_c1_mem_araddr", bus.mem_araddr, 32'h5678_1234);
        chk("t1_c1_lsu_arready", {31'd0, bus.lsu_arready}, 32'h0);
        tick(); bus.ifu_arvalid = 1'b0; @(negedge clk);
        chk("t1_c2_ifu_rvalid", {31'd0, bus.ifu_rvalid}, 32'h1);
        chk("t1_c2_lsu_rvalid", {31'd0, bus.lsu_rvalid}, 32'h0);
        tick(); @(negedge clk);
        chk("t1_c3_grant", {30'd0, grant}, 32'h0);

        // Simultaneous IFU and LSU reads
        tick();
        bus.lsu_araddr = 32'hAAAA_0040; bus.lsu_arvalid = 1'b1;
        bus.ifu_araddr = 32'h0000_8000; bus.ifu_arvalid = 1'b1;
        q_lsu.push_back({32'h0040_AAAA, 2'b00});
        q_ifu.push_back({32'h8000_0000, 2'b00});
        tick(); @(negedge clk);
        chk("t2_c1_grant", {30'd0, grant}, 32'h2);
        chk("t2_c1_mem_araddr", bus.mem_araddr, 32'hAAAA_0040);
        chk("t2_c1_ifu_arready", {31'd0, bus.ifu_arready}, 32'h0);
        tick(); bus.lsu_arvalid = 1'b0; @(negedge clk);
        chk("t2_c2_lsu_rvalid", {31'd0, bus.lsu_rvalid}, 32'h1);
        chk("t2_c2_ifu_arready", {31'd0, bus.ifu_arready}, 32'h0);
        tick(); @(negedge clk);
        chk("t2_c3_idle_grant", {30'd0, grant}, 32'h0);
        chk("t2_c3_mem_arvalid", {31'd0, bus.mem_arvalid}, 32'h0);
        tick(); @(negedge clk);
        chk("t2_c4_grant", {30'd0, grant}, 32'h1);
        chk("t2_c4_mem_araddr", bus.mem_araddr, 32'h0000_8000);
        chk("t2_c4_ifu_arready", {31'd0, bus.ifu_arready}, 32'h1);
        tick(); bus.ifu_arvalid = 1'b0; @(negedge clk);
        chk("t2_c5_ifu_rvalid", {31'd0, bus.ifu_rvalid}, 32'h1);
        tick(); @(negedge clk);
        chk("t2_c6_grant", {30'd0, grant}, 32'h0);

        // LSU write, W two cycles before AW
        tick();
        bus.lsu_wvalid = 1'b1; bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wstrb = 4'b0011;
        q_b.push_back(2'b00);
        tick(); @(negedge clk);
        chk("t3_c2_grant", {30'd0, grant}, 32'h3);
        chk("t3_c2_mem_wvalid", {31'd0, bus.mem_wvalid}, 32'h1);
        chk("t3_c2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("t3_c2_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'h3);
        chk("t3_c2_mem_awvalid", {31'd0, bus.mem_awvalid}, 32'h0);
        chk("t3_c2_lsu_bvalid", {31'd0, bus.lsu_bvalid}, 32'h0);
        tick();
        bus.lsu_awvalid = 1'b1; bus.lsu_awaddr = 32'h8000_1000;
        @(negedge clk);
        chk("t3_c3_mem_wvalid_gated", {31'd0, bus.mem_wvalid}, 32'h0);
        chk("t3_c3_lsu_wready", {31'd0, bus.lsu_wready}, 32'h0);
        chk("t3_c3_mem_awvalid", {31'd0, bus.mem_awvalid}, 32'h1);
        chk("t3_c3_mem_awaddr", bus.mem_awaddr, 32'h8000_1000);
        chk("t3_c3_lsu_bvalid", {31'd0, bus.lsu_bvalid}, 32'h0);
        chk("t3_c3_mem_bready", {31'd0, bus.mem_bready}, 32'h0);
        tick();
        bus.lsu_awvalid = 1'b0; bus.lsu_wvalid = 1'b0;
        @(negedge clk);
        chk("t3_c4_lsu_bvalid", {31'd0, bus.lsu_bvalid}, 32'h1);
        chk("t3_c4_mem_bready", {31'd0, bus.mem_bready}, 32'h1);
        tick(); @(negedge clk);
        chk("t3_c5_grant", {30'd0, grant}, 32'h0);

        // Slave AR wait states; IFU keeps arvalid high past its handshake
        cfg_ar_wait = 3; cfg_r_delay = 2;
        tick();
        bus.ifu_araddr = 32'h0000_00F0; bus.ifu_arvalid = 1'b1;
        q_ifu.push_back({32'h00F0_0000, 2'b00});
        for (int c = 1; c <= 3; c++) begin
            tick(); @(negedge clk);
            chk("t4_wait_mem_arvalid", {31'd0, bus.mem_arvalid}, 32'h1);
            chk("t4_wait_ifu_arready", {31'd0, bus.ifu_arready}, 32'h0);
        end
        tick(); @(negedge clk);
        chk("t4_c4_ifu_arready", {31'd0, bus.ifu_arready}, 32'h1);
        for (int c = 5; c <= 6; c++) begin
            tick(); @(negedge clk);
            chk("t4_post_mem_arvalid", {31'd0, bus.mem_arvalid}, 32'h0);
            chk("t4_post_ifu_rvalid", {31'd0, bus.ifu_rvalid}, 32'h0);
        end
        tick(); @(negedge clk);
        chk("t4_c7_ifu_rvalid", {31'd0, bus.ifu_rvalid}, 32'h1);
        tick(); bus.ifu_arvalid = 1'b0; @(negedge clk);
        chk("t4_c8_grant", {30'd0, grant}, 32'h0);
        tick(); @(negedge clk);
        chk("t4_c9_grant", {30'd0, grant}, 32'h0);
        cfg_ar_wait = 0; cfg_r_delay = 0;

        // Error response on LSU read, then a normal IFU read
        cfg_rresp = 2'b10;
        q_lsu.push_back({32'h2222_1111, 2'b10});
        lsu_read(32'h1111_2222);
        cfg_rresp = 2'b00;
        q_ifu.push_back({32'h4444_3333, 2'b00});
        ifu_read(32'h3333_4444);

        // Reset in the middle of LSU_WR after AW has handshaken
        cfg_wready = 1'b0;
        tick();
        bus.lsu_awaddr = 32'h8000_2000; bus.lsu_awvalid = 1'b1;
        bus.lsu_wdata = 32'h0BAD_F00D; bus.lsu_wstrb = 4'hF; bus.lsu_wvalid = 1'b1;
        wait_for(5, "t6_aw");
        tick();
        bus.lsu_awvalid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_grant", {30'd0, grant}, 32'h0);
        chk("t6_rst_mem_wvalid", {31'd0, bus.mem_wvalid}, 32'h0);
        chk("t6_rst_lsu_wready", {31'd0, bus.lsu_wready}, 32'h0);
        chk("t6_rst_mem_bready", {31'd0, bus.mem_bready}, 32'h0);
        chk("t6_rst_lsu_bvalid", {31'd0, bus.lsu_bvalid}, 32'h0);
        bus.lsu_wvalid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        cfg_wready = 1'b1;
        q_ifu.push_back({32'h0001_0000, 2'b00});
        ifu_read(32'h0000_0001);

        // Fresh write with AW and W together, OKAY-exclusive response forwarded
        cfg_bresp = 2'b01;
        q_b.push_back(2'b01);
        tick();
        bus.lsu_awaddr = 32'h8000_3000; bus.lsu_awvalid = 1'b1;
        bus.lsu_wdata = 32'hCAFE_0001; bus.lsu_wstrb = 4'hF; bus.lsu_wvalid = 1'b1;
        wait_for(5, "t7_aw");
        chk("t7_mem_wvalid", {31'd0, bus.mem_wvalid}, 32'h1);
        chk("t7_mem_awaddr", bus.mem_awaddr, 32'h8000_3000);
        tick();
        bus.lsu_awvalid = 1'b0; bus.lsu_wvalid = 1'b0;
        wait_for(4, "t7_b");
        tick(); @(negedge clk);
        chk("t7_end_grant", {30'd0, grant}, 32'h0);

        tick(); tick();
        chk("sb_drain", q_ifu.size() + q_lsu.size() + q_b.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_23060184_mem_arbiter.md
# ysyx_23060184_mem_arbiter

Two-master to one-slave AXI-lite arbiter that shares the single data/instruction SRAM port between the fetch unit (IFU, read-only) and the load/store unit (LSU, read and write). It sits between the IFU/LSU AXI-lite master ports and the SRAM slave. It grants one complete transaction at a time, routes the granted master's channels through and holds the losing master stalled.

## Interface
Parameters:
- ADDR_W, 32, address width (araddr/awaddr)
- DATA_W, 32, data width (rdata/wdata)
- STRB_W, 4, write strobe width (DATA_W/8)
- RESP_W, 2, rresp/bresp width

Ports:
- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ifu_araddr / ifu_arvalid / ifu_arready  in/in/out  ADDR_W/1/1  IFU read address channel
- ifu_rdata / ifu_rresp / ifu_rvalid / ifu_rready  out/out/out/in  DATA_W/RESP_W/1/1  IFU read data channel
- lsu_araddr / lsu_arvalid / lsu_arready  in/in/out  ADDR_W/1/1  LSU read address channel
- lsu_rdata / lsu_rresp / lsu_rvalid / lsu_rready  out/out/out/in  DATA_W/RESP_W/1/1  LSU read data channel
- lsu_awaddr / lsu_awvalid / lsu_awready  in/in/out  ADDR_W/1/1  LSU write address channel
- lsu_wdata / lsu_wstrb / lsu_wvalid / lsu_wready  in/in/in/out  DATA_W/STRB_W/1/1  LSU write data channel
- lsu_bresp / lsu_bvalid / lsu_bready  out/out/in  RESP_W/1/1  LSU write response channel
- mem_*  mirror set toward the SRAM slave: araddr, arvalid, arready(in), rdata(in), rresp(in), rvalid(in), rready, awaddr, awvalid, awready(in), wdata, wstrb, wvalid, wready(in), bresp(in), bvalid(in), bready
- grant  out  2  debug: 00 idle, 01 IFU read, 10 LSU read, 11 LSU write

## Operation
- FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR.
- IDLE: every master-facing ready/valid output is 0 and every mem_* valid/ready output is 0. At each posedge, requests are sampled with fixed priority:
  - lsu_arvalid -> LSU_RD
  - else lsu_awvalid or lsu_wvalid -> LSU_WR
  - else ifu_arvalid -> IFU_RD
  - LSU outranks IFU because the LSU always holds the older instruction.
- IFU_RD / LSU_RD:
  - Granted master's AR and R channels are wired combinationally to mem_* (valid, ready, addr, data and resp in both directions).
  - An ar_done flag sets on the mem AR handshake. Once it is set, mem_arvalid is forced to 0 even if the master still holds arvalid.
  - The R handshake (mem_rvalid && rready) returns the FSM to IDLE and clears ar_done.
- LSU_WR:
  - AW and W are routed independently. They may handshake in either order or in the same cycle.
  - aw_done and w_done set on their handshakes and gate mem_awvalid/mem_wvalid to 0 afterwards.
  - mem_bready = lsu_bready, and lsu_bvalid = mem_bvalid, only while aw_done && w_done. Otherwise both are 0.
  - The B handshake returns the FSM to IDLE and clears both flags.
- Non-granted master: all its ready/valid outputs are 0. Its data outputs are don't-care and are driven 0.
- rresp/bresp are passed through unmodified. Error responses end the transaction normally; there are no retries.
- mem_awaddr/mem_wdata/mem_wstrb are taken from the LSU in LSU_WR and are 0 otherwise. mem_araddr is taken from the granted reader.

## Timing
- Reset: state=IDLE, all flags=0, grant=00, and every output is 0. This takes effect asynchronously while reset is high.
- Reset mid-transaction abandons the transaction without completing it. The slave must be reset by the same signal.
- Arbitration latency is 1 cycle:
  - A request is visible in cycle N.
  - The grant is registered at the end of cycle N.
  - The mem-side valid appears in cycle N+1 and is combinational with the master's valid from then on.
- At least one IDLE cycle separates consecutive transactions, so back-to-back throughput is at most 1 transaction per 3 cycles with a zero-wait slave.
- Requests arriving during a transaction wait. The priority check happens only in IDLE, so a pending IFU is re-evaluated against the LSU every IDLE cycle.
- Simultaneous lsu_arvalid and lsu_awvalid: the read is served first and the write follows after an IDLE cycle.
- Masters must hold valid and payload stable until their handshake. The arbiter does not register payload.

## Test plan
- IFU-only read, zero-wait slave returning 0x12345678:
  - ifu_arvalid=1 at cycle 0 -> grant=01 and mem_arvalid=1 at cycle 1.
  - ifu_rdata=0x12345678, ifu_rvalid=1 at the slave's R cycle; back to IDLE on the next posedge.
  - lsu_* ready/valid outputs stay 0 throughout.
- Simultaneous IFU and LSU read at cycle 0:
  - grant=10 first and ifu_arready stays 0.
  - After the LSU R handshake, one IDLE cycle, then grant=01 and the IFU completes.
- LSU write with W before AW (wvalid cycle 1, awvalid cycle 3, wdata=0xDEADBEEF, wstrb=4'b0011):
  - mem_wvalid drops after the W handshake.
  - lsu_bvalid stays 0 until both handshakes are done.
  - bresp=2'b00 is forwarded and the FSM returns to IDLE.
- Slave AR wait states (mem_arready low 3 cycles, rvalid 2 cycles after AR):
  - mem_arvalid is held, and is forced 0 after the handshake while ifu_arvalid is still 1.
  - A single R is delivered.
- Slave returns rresp=2'b10 on an LSU read -> lsu_rresp=2'b10, the transaction completes and the next IFU request is granted normally.
- Reset asserted mid-LSU_WR after the AW handshake:
  - All outputs go to 0 immediately and grant=00.
  - After release, a new IFU read completes with no stale aw_done/w_done effect.
